serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle unsigned/two's-complement subtractor, the inverse operation of the
//   32-bit adder: computes d = a - b - bin by processing DIGIT bits per cycle with a
//   DIGIT-wide full-adder slice, using a + ~b + ~bin internally. Sits beside the
//   adders as an area-lean datapath unit behind a valid/ready handshake.
// PARAMETERS
//   WIDTH  32  operand/result width in bits
//   DIGIT  4   bits processed per cycle; WIDTH % DIGIT must be 0 (elaboration error otherwise)
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands a, b, bin valid
//   in_ready   out  1      block can accept operands
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow in
//   out_valid  out  1      d, bout, ovf valid
//   out_ready  in   1      consumer accepts result
//   d          out  WIDTH  difference, (a - b - bin) mod 2^WIDTH
//   bout       out  1      borrow out: 1 iff a < b + bin (unsigned)
//   ovf        out  1      signed overflow of a - b - bin (two's complement)
// BEHAVIOUR
//   - Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0,
//     d=0, bout=0, ovf=0, digit counter=0, operand registers=0.
//   - NDIG = WIDTH/DIGIT. States IDLE, RUN, DONE.
//   - IDLE: in_ready=1. On in_valid&in_ready at edge k: latch a, ~b, carry=~bin,
//     counter=0, go RUN. in_ready=0 from edge k onward.
//   - RUN: each cycle add digit [counter*DIGIT +: DIGIT] of a and ~b with carry;
//     write sum digit into d register, update carry, counter++. After NDIG cycles
//     go DONE. Inputs ignored in RUN/DONE.
//   - Latency: out_valid rises at edge k+NDIG (8 cycles for defaults).
//   - DONE: out_valid=1; bout = ~final carry; ovf = (a[MSB]!=b[MSB]) &&
//     (d[MSB]!=a[MSB]). d/bout/ovf stable while out_valid&&!out_ready.
//   - out_valid&out_ready at edge m: out_valid=0, go IDLE, in_ready=1 from edge m.
//     No accept in the same cycle as result handoff (max throughput 1 per NDIG+2).
//   - d/bout/ovf hold last result in IDLE until next RUN overwrites d digitwise;
//     consumers sample only when out_valid=1.
//   - rst_n low at any point (incl. mid-RUN or DONE): abort, return to reset values.
//   - DIGIT==WIDTH legal: NDIG=1, single RUN cycle.
// TESTING
//   1. a=0x0000_000A, b=0x0000_0003, bin=0 -> after 8 clk d=0x0000_0007, bout=0, ovf=0.
//   2. a=0, b=1, bin=0 -> d=0xFFFF_FFFF, bout=1, ovf=0; a=0, b=0, bin=1 -> same result.
//   3. a=0x8000_0000, b=1, bin=0 -> d=0x7FFF_FFFF, bout=0, ovf=1; a=0x7FFF_FFFF,
//      b=0xFFFF_FFFF -> d=0x8000_0000, bout=1, ovf=1.
//   4. Backpressure: out_ready=0 for 5 cycles after out_valid -> d/bout/ovf stable,
//      in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next edge.
//   5. Assert rst_n=0 at RUN cycle 4 -> out_valid=0, in_ready=1, d=0 immediately;
//      new op after release completes correctly in 8 cycles.
//   6. 10k random a/b/bin, random out_ready stalls, also WIDTH=32 DIGIT=1/32 ->
//      d, bout, ovf match reference model ({bout,d} = {1'b0,a}-{1'b0,b}-bin).

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Handshake bundle for the digit-serial subtractor: operand side and result side.
interface serial_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    // Producer/consumer side: supplies operands and accepts results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - bin, evaluated DIGIT bits per cycle as
// a + ~b + ~bin through one DIGIT-wide adder slice.
//
// state | meaning
// IDLE  | ready for operands, result registers hold the last result
// RUN   | one digit per cycle, LSB digit first
// DONE  | result valid, held until the consumer takes it
//
// The interface instance must be built with the same WIDTH as this module.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
            $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] nb_q;      // subtrahend stored inverted
    logic [WIDTH-1:0] d_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             bout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] nb_dig;
    logic [DIGIT:0]   sum;
    logic             last;

    // Adder slice on the digit selected by the counter.
    always_comb begin
        a_dig  = a_q[int'(cnt) * DIGIT +: DIGIT];
        nb_dig = nb_q[int'(cnt) * DIGIT +: DIGIT];
        sum    = {1'b0, a_dig} + {1'b0, nb_dig} + {{DIGIT{1'b0}}, carry};
        last   = (cnt == CW'(NDIG - 1));
    end

    // Sequencer and datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            d_q         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        nb_q       <= ~bus.b;
                        carry      <= ~bus.bin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    d_q[int'(cnt) * DIGIT +: DIGIT] <= sum[DIGIT-1:0];
                    carry <= sum[DIGIT];
                    if (last) begin
                        cnt         <= '0;
                        out_valid_q <= 1'b1;
                        bout_q      <= ~sum[DIGIT];
                        // a and b signs differ (a MSB equals inverted-b MSB) and
                        // the result sign differs from a.
                        ovf_q       <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) &&
                                       (sum[DIGIT-1] != a_q[WIDTH-1]);
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
endmodule
